// File: rtl/bcdn_counter_pkg.sv
// ---------------------------------------------------------------------------
// bcdn_counter_pkg
// Shared constants and helpers for the cascaded BCD counter:
//   DIGIT_W     - bit width of one BCD digit
//   BCD_MAX     - largest legal digit value (9)
//   BCD_MIN     - smallest legal digit value (0)
//   digit_valid - 1 when a 4-bit nibble is a legal BCD digit
// ---------------------------------------------------------------------------
package bcdn_counter_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

   function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcdn_counter_if.sv
// ---------------------------------------------------------------------------
// bcdn_counter_if
// Control/data bundle of the BCD counter.
//   master : drives x, up, clr, load, load_val; observes the results
//   slave  : the counter; drives bcd_out, carry, ovf, load_err
// Digit i of load_val / bcd_out sits at bits [4i+3:4i], digit 0 least significant.
// ---------------------------------------------------------------------------
interface bcdn_counter_if
   import bcdn_counter_pkg::*;
   #(parameter int DIGITS = 4);

   logic                      x;
   logic                      up;
   logic                      clr;
   logic                      load;
   logic [DIGIT_W*DIGITS-1:0] load_val;
   logic [DIGIT_W*DIGITS-1:0] bcd_out;
   logic                      carry;
   logic                      ovf;
   logic                      load_err;

   modport master (
      output x, up, clr, load, load_val,
      input  bcd_out, carry, ovf, load_err
   );

   modport slave (
      input  x, up, clr, load, load_val,
      output bcd_out, carry, ovf, load_err
   );

endinterface

// File: rtl/bcdn_counter_bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One registered BCD digit with priority clr > load > step.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   step_en      - advance this digit one step on the edge
//   up           - 1 = increment, 0 = decrement
//   clr          - synchronous clear to 0
//   load         - synchronous load of load_digit (caller guarantees validity)
//   load_digit   - value to load
//   digit        - current registered digit value
//   at_max/at_min- digit currently 9 / 0 (feeds the ripple enable chain)
// ---------------------------------------------------------------------------
module bcd_digit
   import bcdn_counter_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               step_en,
   input  logic               up,
   input  logic               clr,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_digit,
   output logic [DIGIT_W-1:0] digit,
   output logic               at_max,
   output logic               at_min
);

   logic [DIGIT_W-1:0] digit_r;
   logic [DIGIT_W-1:0] digit_next_s;

   // Next digit value: clear, load, step with 9<->0 wrap, else hold.
   always_comb begin
      digit_next_s = digit_r;
      if (clr) begin
         digit_next_s = BCD_MIN;
      end else if (load) begin
         digit_next_s = load_digit;
      end else if (step_en) begin
         if (up) begin
            // >= also folds any illegal value back to 0
            digit_next_s = (digit_r >= BCD_MAX) ? BCD_MIN : (digit_r + 4'd1);
         end else begin
            digit_next_s = (digit_r == BCD_MIN) ? BCD_MAX : (digit_r - 4'd1);
         end
      end else begin
         digit_next_s = digit_r;
      end
   end

   // Digit state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit_r <= BCD_MIN;
      end else begin
         digit_r <= digit_next_s;
      end
   end

   assign digit  = digit_r;
   assign at_max = (digit_r == BCD_MAX);
   assign at_min = (digit_r == BCD_MIN);

endmodule

// File: rtl/bcdn_counter.sv
// ---------------------------------------------------------------------------
// bcdn_counter
// DIGITS-digit cascaded BCD up/down counter with clear, validated parallel
// load, combinational ripple carry, sticky wrap flag and load-error pulse.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - bcdn_counter_if.slave (x, up, clr, load, load_val in;
//           bcd_out, carry, ovf, load_err out)
// ---------------------------------------------------------------------------
module bcdn_counter
   import bcdn_counter_pkg::*;
   #(parameter int DIGITS = 4)
(
   input  logic           clk,
   input  logic           reset,
   bcdn_counter_if.slave  bus
);

   logic [DIGITS:0]           en_s;
   logic [DIGITS-1:0]         at_max_s;
   logic [DIGITS-1:0]         at_min_s;
   logic [DIGITS-1:0]         valid_s;
   logic [DIGIT_W*DIGITS-1:0] count_s;
   logic                      load_ok_s;
   logic                      load_bad_s;
   logic                      step_gate_s;
   logic                      ovf_r;
   logic                      ovf_next_s;
   logic                      load_err_r;

   // Ripple enable: digit i steps only when every lower digit is at its
   // terminal value for the current direction. en_s[DIGITS] is the full wrap.
   assign en_s[0] = bus.x;

   // A load request, accepted or rejected, pre-empts counting this edge.
   assign step_gate_s = ~bus.load;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign valid_s[gi]  = digit_valid(bus.load_val[DIGIT_W*gi +: DIGIT_W]);
         assign en_s[gi+1]   = en_s[gi] & (bus.up ? at_max_s[gi] : at_min_s[gi]);

         bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .step_en    (en_s[gi] & step_gate_s),
            .up         (bus.up),
            .clr        (bus.clr),
            .load       (load_ok_s),
            .load_digit (bus.load_val[DIGIT_W*gi +: DIGIT_W]),
            .digit      (count_s[DIGIT_W*gi +: DIGIT_W]),
            .at_max     (at_max_s[gi]),
            .at_min     (at_min_s[gi])
         );
      end
   endgenerate

   assign load_ok_s  = bus.load & (&valid_s);
   assign load_bad_s = bus.load & ~(&valid_s) & ~bus.clr;

   // Sticky wrap flag: clr clears it, any load suppresses a same-cycle wrap.
   always_comb begin
      ovf_next_s = ovf_r;
      if (bus.clr) begin
         ovf_next_s = 1'b0;
      end else if (bus.load) begin
         ovf_next_s = ovf_r;
      end else if (en_s[DIGITS]) begin
         ovf_next_s = 1'b1;
      end else begin
         ovf_next_s = ovf_r;
      end
   end

   // Status flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_r      <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         ovf_r      <= ovf_next_s;
         load_err_r <= load_bad_s;
      end
   end

   assign bus.bcd_out  = count_s;
   assign bus.carry    = en_s[DIGITS];
   assign bus.ovf      = ovf_r;
   assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_bcdn_counter.sv
// ---------------------------------------------------------------------------
// tb_bcdn_counter
// Scoreboard bench for bcdn_counter (DIGITS=4). Stimulus drives one cycle per
// call and queues the expected post-edge state; a monitor pops and compares
// one entry after each rising edge. Combinational carry and asynchronous
// reset are checked directly where they are observable.
// ---------------------------------------------------------------------------
module tb_bcdn_counter;

   localparam int DIGITS = 4;

   typedef struct {
      string       name;
      logic [15:0] bcd;
      logic        ovf;
      logic        lerr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   bcdn_counter_if #(.DIGITS(DIGITS)) bus ();

   bcdn_counter #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // One stimulus cycle: drive inputs after the falling edge, queue expectation.
   task automatic cyc(input logic x, input logic up, input logic clr, input logic load,
                      input logic [15:0] lv, input string nm,
                      input logic [15:0] eb, input logic eo, input logic el);
      exp_t e;
      @(negedge clk);
      bus.x = x; bus.up = up; bus.clr = clr; bus.load = load; bus.load_val = lv;
      e.name = nm; e.bcd = eb; e.ovf = eo; e.lerr = el;
      exp_q.push_back(e);
   endtask

   // Monitor: compare one queued expectation after each rising edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".bcd"}, {16'd0, bus.bcd_out}, {16'd0, e.bcd});
            chk({e.name, ".ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
            chk({e.name, ".lerr"}, {31'd0, bus.load_err}, {31'd0, e.lerr});
         end
      end
   end

   initial begin : stim
      reset = 1'b0;
      bus.x = 1'b0; bus.up = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 16'h0000;
      #1;
      chk("rst.bcd", {16'd0, bus.bcd_out}, 32'h0);
      chk("rst.ovf", {31'd0, bus.ovf}, 32'h0);
      chk("rst.lerr", {31'd0, bus.load_err}, 32'h0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;

      // Increment across digit boundaries, carry low.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0998, "ld0998", 16'h0998, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "up0999", 16'h0999, 1'b0, 1'b0);
      #1 chk("carry0998", {31'd0, bus.carry}, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "up1000", 16'h1000, 1'b0, 1'b0);
      #1 chk("carry0999", {31'd0, bus.carry}, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "up1001", 16'h1001, 1'b0, 1'b0);
      #1 chk("carry1000", {31'd0, bus.carry}, 32'h0);

      // Full up-wrap from 9999.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, "ld9999", 16'h9999, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "wrapup", 16'h0000, 1'b1, 1'b0);
      #1 chk("carry9999dn", {31'd0, bus.carry}, 32'h0);
      bus.up = 1'b1;
      #1 chk("carry9999up", {31'd0, bus.carry}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "ovfhold", 16'h0000, 1'b1, 1'b0);
      end

      // Load keeps ovf; asynchronous reset mid-count clears everything.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0473, "ld0473", 16'h0473, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "up0474", 16'h0474, 1'b1, 1'b0);
      @(negedge clk);
      bus.x = 1'b1; bus.up = 1'b1; bus.load = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("arst.bcd", {16'd0, bus.bcd_out}, 32'h0);
      chk("arst.ovf", {31'd0, bus.ovf}, 32'h0);
      chk("arst.lerr", {31'd0, bus.load_err}, 32'h0);
      @(negedge clk);
      bus.x = 1'b0;
      reset = 1'b1;

      // Down-wrap from 0000, then clr beats x.
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "ld0000", 16'h0000, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "wrapdn", 16'h9999, 1'b1, 1'b0);
      #1 chk("carry0000dn", {31'd0, bus.carry}, 32'h1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "clr", 16'h0000, 1'b0, 1'b0);
      #1 chk("carry9999dnclr", {31'd0, bus.carry}, 32'h0);

      // Rejected load: count held, one-cycle error pulse.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042, "ld0042", 16'h0042, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h12A4, "badld", 16'h0042, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "lerrgone", 16'h0042, 1'b0, 1'b0);

      // Direction changes without dead cycles, borrow across digits.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "up0043", 16'h0043, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "dn0042", 16'h0042, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "dn0041", 16'h0041, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000, "ld1000", 16'h1000, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "dn0999", 16'h0999, 1'b0, 1'b0);

      // Load wins over a wrap: no ovf, carry still reflects x/state.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, "ld9999b", 16'h9999, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0123, "ldwrap", 16'h0123, 1'b0, 1'b0);
      #1 chk("carryload", {31'd0, bus.carry}, 32'h1);

      // clr beats load and x at 9999.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, "ld9999c", 16'h9999, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, "clrall", 16'h0000, 1'b0, 1'b0);

      // Rejected load also blocks counting; a good load clears the error.
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'hF000, "badldx", 16'h0000, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, "ld0005", 16'h0005, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "idle", 16'h0005, 1'b0, 1'b0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
      end
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcdn_counter.md
BCDN_COUNTER -- requirements
Module: bcdn_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded BCD digits; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 x  input  1  count enable; 1 = advance one step this edge.
REQ-005 up  input  1  direction; 1 = count up, 0 = count down.
REQ-006 clr  input  1  synchronous clear to all-zero.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 load_val  input  4*DIGITS  load value; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-009 bcd_out  output  4*DIGITS  current count, same digit packing as load_val.
REQ-010 carry  output  1  combinational terminal-count/ripple-out for cascading further counters.
REQ-011 ovf  output  1  registered sticky wrap flag.
REQ-012 load_err  output  1  registered one-cycle pulse flagging a rejected load.

Function
REQ-013 Per edge, the block SHALL apply priority clr > load > x; with none asserted, state holds.
REQ-014 clr=1 SHALL set every digit to 0 and clear ovf; load_err SHALL be 0 that cycle.
REQ-015 load=1 (clr=0) with every load_val digit in 0..9 SHALL copy load_val into the count; ovf unchanged.
REQ-016 load=1 (clr=0) with any digit in 10..15 SHALL leave the count unchanged and set load_err=1 for exactly the following cycle.
REQ-017 load_err SHALL be 0 on every cycle not following a rejected load.
REQ-018 x=1, up=1: digit 0 SHALL increment; digit i>0 SHALL increment only when all lower digits are 9; a digit at 9 that increments SHALL become 0.
REQ-019 x=1, up=0: digit 0 SHALL decrement; digit i>0 SHALL decrement only when all lower digits are 0; a digit at 0 that decrements SHALL become 9.
REQ-020 Counting latency SHALL be one edge: bcd_out shows the new value after the edge where x was sampled 1.
REQ-021 carry SHALL equal x & ((up & all digits 9) | (~up & all digits 0)), purely combinational, with no dependence on clr/load.
REQ-022 On full wrap (all 9 to all 0 up, or all 0 to all 9 down), ovf SHALL set to 1 and stay 1 until clr or reset.
REQ-023 If clr or load is asserted in the same cycle as a wrap condition, ovf SHALL NOT set from that wrap (clr/load win).
REQ-024 Direction change between cycles SHALL take effect on the next counting edge with no dead cycle.
REQ-025 The count SHALL never hold a digit value 10..15 in any reachable state.

Reset
REQ-026 reset=0 SHALL asynchronously force bcd_out to all-zero, ovf=0, and load_err=0, independent of clk.
REQ-027 reset asserted mid-count or mid-load SHALL discard the in-flight operation; the first edge after reset deassertion SHALL evaluate inputs normally.

Structure
REQ-028 A shared package SHALL hold BCD_MAX (4'd9), BCD_MIN (4'd0), the digit width constant (4), and a function or constant for digit validity.
REQ-029 A sub-module bcd_digit SHALL implement one digit: inputs step enable, up, clr, load, load digit; outputs digit value, at_max, and at_min. bcdn_counter SHALL instantiate DIGITS of these with a generate loop.
REQ-030 The enable chain between digits SHALL be combinational AND of lower at_max/at_min flags, with no extra pipeline stage.

Verification (DIGITS=4)
REQ-031 Reset mid-count at 0x0473 -> bcd_out=0x0000, ovf=0, load_err=0 immediately, before any clk edge.
REQ-032 Load 0x0998, then x=1 up=1 for 3 edges -> 0x0999, 0x1000, 0x1001; carry=0 throughout.
REQ-033 Load 0x9999, x=1 up=1 -> carry=1 before the edge; after the edge bcd_out=0x0000 and ovf=1; ovf stays 1 for 5 further idle cycles.
REQ-034 Load 0x0000, x=1 up=0 -> bcd_out=0x9999 and ovf=1; then clr=1 with x=1 -> bcd_out=0x0000 and ovf=0.
REQ-035 Count at 0x0042, load=1 with load_val=0x12A4 -> bcd_out stays 0x0042 and load_err=1 for exactly one cycle.
REQ-036 Simultaneous clr=1, load=1 (0x5555), x=1 at 0x9999 -> bcd_out=0x0000, ovf=0, load_err=0.
